// File: rtl/cdb_arbiter.sv
// Two-slot common-data-bus arbiter: picks up to two completed functional-unit results per cycle
// and broadcasts them one cycle later. Define CDB_ARB_ROUNDROBIN_EN for round-robin selection;
// otherwise selection is fixed priority from requester 0 upward.
module cdb_arbiter #(
   parameter int          NUM_REQ  = 4,
   parameter logic [7:0]  TAG_NULL = 8'hFF
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       fu_valid_in,
   input  logic [8*NUM_REQ-1:0]     fu_tag_in,
   input  logic [64*NUM_REQ-1:0]    fu_value_in,
   input  logic [NUM_REQ-1:0]       fu_mispredicted_in,
   input  logic                     flush_in,
   output logic [NUM_REQ-1:0]       fu_grant_out,
   output logic [7:0]               cdb1_tag_out,
   output logic [63:0]              cdb1_value_out,
   output logic                     cdb1_mispredicted_out,
   output logic [7:0]               cdb2_tag_out,
   output logic [63:0]              cdb2_value_out,
   output logic                     cdb2_mispredicted_out
);

   localparam int IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]  w_elig;
   logic [IW-1:0]       w_start;
   logic [IW-1:0]       w_idx;
   logic                w_first_vld;
   logic [IW-1:0]       w_first_idx;
   logic                w_second_vld;
   logic [IW-1:0]       w_second_idx;
   logic                w_gate;

   logic [7:0]          r_cdb1_tag;
   logic [63:0]         r_cdb1_value;
   logic                r_cdb1_mp;
   logic [7:0]          r_cdb2_tag;
   logic [63:0]         r_cdb2_value;
   logic                r_cdb2_mp;

   // A result carrying the null tag would be indistinguishable from an idle slot, so it is never granted.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_elig[i] = fu_valid_in[i] && (fu_tag_in[8*i +: 8] != TAG_NULL);
      end
   end

`ifdef CDB_ARB_ROUNDROBIN_EN
   logic [IW-1:0] r_rr_ptr;

   assign w_start = r_rr_ptr;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rr_ptr <= '0;
      end else if (w_gate && w_first_vld) begin
         r_rr_ptr <= (w_second_vld ? w_second_idx : w_first_idx) + 1'b1;
      end
   end
`else
   assign w_start = '0;
`endif

   always_comb begin
      w_idx        = '0;
      w_first_vld  = 1'b0;
      w_first_idx  = '0;
      w_second_vld = 1'b0;
      w_second_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = w_start + IW'(k);
         if (w_elig[w_idx]) begin
            if (!w_first_vld) begin
               w_first_vld = 1'b1;
               w_first_idx = w_idx;
            end else if (!w_second_vld) begin
               w_second_vld = 1'b1;
               w_second_idx = w_idx;
            end
         end
      end
   end

   assign w_gate = !reset && !flush_in;

   always_comb begin
      fu_grant_out = '0;
      if (w_gate && w_first_vld)  fu_grant_out[w_first_idx]  = 1'b1;
      if (w_gate && w_second_vld) fu_grant_out[w_second_idx] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!w_gate || !w_first_vld) begin
         r_cdb1_tag   <= TAG_NULL;
         r_cdb1_value <= '0;
         r_cdb1_mp    <= 1'b0;
      end else begin
         r_cdb1_tag   <= fu_tag_in[8*w_first_idx +: 8];
         r_cdb1_value <= fu_value_in[64*w_first_idx +: 64];
         r_cdb1_mp    <= fu_mispredicted_in[w_first_idx];
      end
      if (!w_gate || !w_second_vld) begin
         r_cdb2_tag   <= TAG_NULL;
         r_cdb2_value <= '0;
         r_cdb2_mp    <= 1'b0;
      end else begin
         r_cdb2_tag   <= fu_tag_in[8*w_second_idx +: 8];
         r_cdb2_value <= fu_value_in[64*w_second_idx +: 64];
         r_cdb2_mp    <= fu_mispredicted_in[w_second_idx];
      end
   end

   assign cdb1_tag_out          = r_cdb1_tag;
   assign cdb1_value_out        = r_cdb1_value;
   assign cdb1_mispredicted_out = r_cdb1_mp;
   assign cdb2_tag_out          = r_cdb2_tag;
   assign cdb2_value_out        = r_cdb2_value;
   assign cdb2_mispredicted_out = r_cdb2_mp;

endmodule
